// File: rtl/sindoku_ssd_scan.sv
// Eight-digit seven-segment scan driver with a tear-free double buffer.
// Define SSD_BLINK_EN to build the cursor-digit blink logic.
module sindoku_ssd_scan #(
  parameter int unsigned SCAN_BITS  = 18,
  parameter int unsigned BLINK_BITS = 25
) (
  input  logic        board_clk,
  input  logic        Reset,
  input  logic        load,
  input  logic [31:0] digits_in,
  input  logic [7:0]  blank_in,
  input  logic [7:0]  dp_in,
  input  logic [2:0]  cursor_in,
  output logic [7:0]  An,
  output logic [7:0]  Cath,
  output logic        frame_start
);

  localparam int unsigned CNT_W = SCAN_BITS + 3;

  typedef struct packed {
    logic [31:0] digits;
    logic [7:0]  blank;
    logic [7:0]  dp;
    logic [2:0]  cursor;
  } disp_t;

  localparam disp_t DISP_RST = '{digits: 32'h0, blank: 8'hFF, dp: 8'h00, cursor: 3'h0};

  logic [CNT_W-1:0]     scan_cnt_q, scan_cnt_d;
  disp_t                pend_q, pend_d;
  disp_t                act_q, act_d;
  disp_t                in_s;
  logic [7:0]           an_q, an_d;
  logic [7:0]           cath_q, cath_d;
  logic                 frame_start_q, frame_start_d;
  logic                 eof;
  logic [2:0]           digit_idx;
  logic [SCAN_BITS-1:0] slot_off;
  logic [3:0]           nib;
  logic [6:0]           seg_n;
  logic                 blink_dark;
  logic                 dark;

  assign in_s      = {digits_in, blank_in, dp_in, cursor_in};
  assign eof       = &scan_cnt_q;
  assign digit_idx = scan_cnt_q[CNT_W-1 -: 3];
  assign slot_off  = scan_cnt_q[SCAN_BITS-1:0];

`ifdef SSD_BLINK_EN
  logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;
  logic                  blink_off_q, blink_off_d;

  // Phase flips on each wrap of the blink counter; starts in the lit phase.
  always_comb begin
    blink_cnt_d = blink_cnt_q + BLINK_BITS'(1);
    blink_off_d = blink_off_q;
    if (&blink_cnt_q) begin
      blink_off_d = ~blink_off_q;
    end
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
    end
  end

  assign blink_dark = blink_off_q && (digit_idx == act_q.cursor);
`else
  logic unused_ok;
  assign unused_ok  = ^{act_q.cursor, 32'(BLINK_BITS)};
  assign blink_dark = 1'b0;
`endif

  // Pending captures every load; active takes pending (or a coincident load) at end of frame.
  always_comb begin
    scan_cnt_d = scan_cnt_q + CNT_W'(1);
    pend_d     = pend_q;
    act_d      = act_q;
    if (load) begin
      pend_d = in_s;
    end
    if (eof) begin
      act_d = pend_d;
    end
  end

  // Active-low {a,b,c,d,e,f,g} hex decode.
  always_comb begin
    nib   = act_q.digits[{digit_idx, 2'b00} +: 4];
    seg_n = 7'h7F;
    case (nib)
      4'h0: seg_n = 7'b0000001;
      4'h1: seg_n = 7'b1001111;
      4'h2: seg_n = 7'b0010010;
      4'h3: seg_n = 7'b0000110;
      4'h4: seg_n = 7'b1001100;
      4'h5: seg_n = 7'b0100100;
      4'h6: seg_n = 7'b0100000;
      4'h7: seg_n = 7'b0001111;
      4'h8: seg_n = 7'b0000000;
      4'h9: seg_n = 7'b0000100;
      4'hA: seg_n = 7'b0001000;
      4'hB: seg_n = 7'b1100000;
      4'hC: seg_n = 7'b0110001;
      4'hD: seg_n = 7'b1000010;
      4'hE: seg_n = 7'b0110000;
      4'hF: seg_n = 7'b0111000;
      default: seg_n = 7'h7F;
    endcase
  end

  // Offset 0 of every slot is a dead cycle so the previous digit cannot ghost.
  always_comb begin
    an_d          = 8'hFF;
    cath_d        = 8'hFF;
    dark          = act_q.blank[digit_idx] || (slot_off == '0) || blink_dark;
    frame_start_d = (scan_cnt_q == CNT_W'(1));
    if (!dark) begin
      an_d   = ~(8'(1) << digit_idx);
      cath_d = {seg_n, ~act_q.dp[digit_idx]};
    end
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      scan_cnt_q    <= '0;
      pend_q        <= DISP_RST;
      act_q         <= DISP_RST;
      an_q          <= 8'hFF;
      cath_q        <= 8'hFF;
      frame_start_q <= 1'b0;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      pend_q        <= pend_d;
      act_q         <= act_d;
      an_q          <= an_d;
      cath_q        <= cath_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign An          = an_q;
  assign Cath        = cath_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/sindoku_ssd_scan.md
# sindoku_ssd_scan

Time-multiplexed driver for the Nexys-4 eight-digit seven-segment display in the SINdoku game. It sits downstream of the game state machine, which presents eight hex nibbles plus per-digit blank and decimal-point masks and a cursor index. The block double-buffers those values so a frame never tears, scans the digits at a refresh rate visible as steady light, and drives the active-low anodes and cathodes directly. Optionally, it blinks the cursor digit.

## Interface
- SCAN_BITS, 18, log2 of clock cycles per digit slot (100 MHz/2^18 ≈ 381 Hz per digit, ≈ 48 Hz per frame).
- BLINK_BITS, 25, log2 of the blink half-period in cycles (≈ 0.34 s). Used only with SSD_BLINK_EN.

Ports:
- board_clk  in  1  100 MHz clock.
- Reset  in  1  asynchronous, active-high.
- load  in  1  single-cycle strobe that captures digits_in, blank_in, dp_in and cursor_in into the pending buffer.
- digits_in  in  32  digit i = digits_in[4i+3:4i], displayed on An[i].
- blank_in  in  8  1 = digit i is dark.
- dp_in  in  8  1 = decimal point of digit i is lit.
- cursor_in  in  3  index of the digit to blink.
- An  out  8  active-low anodes.
- Cath  out  8  active-low {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}.
- frame_start  out  1  one-cycle pulse.

## Operation
- **Registers:**
  - scan_cnt is SCAN_BITS+3 bits and free-running, incrementing every cycle with wrap.
  - The digit index is scan_cnt[MSB:SCAN_BITS]. The slot offset is scan_cnt[SCAN_BITS-1:0].
- **Double buffer:**
  - A cycle with load=1 writes all four inputs into the pending registers.
  - In the cycle where scan_cnt is all-ones (end of frame), pending is copied into active.
  - If load and end-of-frame coincide, the new input values go into both pending and active (bypass).
  - load held high for multiple cycles is legal; the last cycle's values win.
- **Digit decode:**
  - Standard hex-to-segment decode (0–F) from active digits.
  - Dp cathode = ~active_dp[i].
- **Dark conditions:** a digit is dark (An[i]=1, Cath=8'hFF) when any of the following holds:
  - active_blank[i] is set;
  - guard: the slot offset is 0 (one dead cycle per slot to prevent ghosting);
  - blink off-phase with i == active_cursor (SSD_BLINK_EN only).
- **Anodes:** at most one An bit is low at any time.
- **frame_start:** asserted in the cycle the outputs first reflect digit 0 of a new frame.
- **Reset values:**
  - scan_cnt = 0, blink counter = 0.
  - pending/active digits = 0, blank = 8'hFF, dp = 0, cursor = 0.
  - An = 8'hFF, Cath = 8'hFF, frame_start = 0.
- **Reset mid-frame:** immediate return to the reset values. Scanning restarts at digit 0, and the display stays dark until the first load followed by an end of frame.

## Timing
- An, Cath and frame_start are registered. The outputs at cycle k reflect scan_cnt and active at cycle k-1.
- Slot for digit d: the outputs show the guard (all dark) for 1 cycle, then digit d for 2^SCAN_BITS − 1 cycles.
- Load-to-display latency: from the load cycle, the new data is visible starting with the first digit-0 slot after the next end of frame. The worst case is 2^(SCAN_BITS+3) + 2 cycles.
- Blink: the phase toggles when the BLINK_BITS counter wraps. A phase change takes effect at the next register update, not at a slot boundary.

## Configuration
- **SSD_BLINK_EN defined:**
  - The BLINK_BITS counter and phase flop exist.
  - The cursor digit is dark during the off-phase (the phase starts "on" after reset).
- **SSD_BLINK_EN undefined:**
  - No blink logic is built and cursor_in is ignored, though its pending/active registers may be optimized away.
  - The cursor digit displays like any other digit.

## Test plan
Simulation uses SCAN_BITS=2 and BLINK_BITS=5: 4-cycle slots and 32-cycle frames.
- **Reset:** assert Reset mid-frame → An=8'hFF, Cath=8'hFF, frame_start=0 in the same cycle. After release, no digit lights until a load is followed by an end of frame.
- **Single digit:** load digits_in=32'h0000_0007, blank_in=8'hFE, dp_in=0 → in the digit-0 slot, An=8'hFE and Cath=8'b00011111 for 3 cycles after a 1-cycle all-dark guard. All other slots are dark.
- **Full scan:** load digits 32'h7654_3210, blank_in=0 →
  - An walks FE, FD, … 7F over 32 cycles, with cathodes matching 0…7;
  - frame_start pulses once every 32 cycles, coincident with An=8'hFE.
- **No tearing:** issue a second load (all 8s) while the digit-3 slot is displayed → digits 4–7 of the current frame still show the old values; the next frame shows all 8s.
- **Coincident load:** load asserted exactly when scan_cnt=5'h1F → the new data is shown in the immediately following frame.
- **Blink:** with SSD_BLINK_EN, cursor_in=2 and all digits unblanked → digit 2 is dark in alternating 32-cycle windows and the other digits are unaffected. Without the macro, digit 2 is always lit.
